shared_mux_arbiter: RTL

- Round-robin arbiter that shares one registered N:1 mux output lane between N requesters.
- Each requester holds `req` high while it owns the lane.
- The arbiter drives a one-hot grant and a binary select into the mux, and registers the selected data.
- It sits in front of the team's mux-based datapath blocks, so multiple sources can time-share one downstream consumer.

---
 rtl/shared_mux_arbiter_pkg.sv | 26 ++
 rtl/shared_mux_arbiter_if.sv | 47 ++++
 rtl/shared_mux_arbiter_rr_pick.sv | 36 +++
 rtl/shared_mux_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/shared_mux_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shared_mux_pkg
// Shared types and constants for the shared-lane round-robin arbiter.
//   state_t    : arbiter FSM state (IDLE = no owner, BUSY = lane owned)
//   DEF_N      : default requester count
//   DEF_W      : default data width per requester
//   SEL_W      : select width for the default requester count
//   sel_width(): index width for an n-entry select (never below 1 bit)
// -----------------------------------------------------------------------------
package shared_mux_pkg;

    localparam int DEF_N = 4;
    localparam int DEF_W = 8;
    localparam int SEL_W = $clog2(DEF_N);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Width of a binary index into n entries; a 1-entry space still needs a bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_mux_arbiter_if.sv
// -----------------------------------------------------------------------------
// shared_mux_arbiter_if
// Bundle between N requesters and the shared output lane.
//   req      [N]        : request per requester, held while the lane is wanted
//   din      [N*W]      : flattened data, requester i at [i*W +: W]
//   gnt      [N]        : one-hot grant
//   sel      [SEL_BITS] : binary index of the current owner
//   dout     [W]        : registered lane output
//   dout_vld            : dout carries owner data this cycle
// Modports:
//   master : requester side (drives req/din, observes the lane)
//   slave  : arbiter side (receives req/din, drives the lane)
// -----------------------------------------------------------------------------
interface shared_mux_arbiter_if
    import shared_mux_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
);
    localparam int SEL_BITS = sel_width(N);

    logic [N-1:0]        req;
    logic [N*W-1:0]      din;
    logic [N-1:0]        gnt;
    logic [SEL_BITS-1:0] sel;
    logic [W-1:0]        dout;
    logic                dout_vld;

    modport master (
        output req,
        output din,
        input  gnt,
        input  sel,
        input  dout,
        input  dout_vld
    );

    modport slave (
        input  req,
        input  din,
        output gnt,
        output sel,
        output dout,
        output dout_vld
    );

endinterface

// File: rtl/shared_mux_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotate-priority search: returns the first asserted request
// found when scanning ptr, ptr+1, ... wrapping modulo N.
//   req   [N]        : request vector
//   ptr   [SEL_BITS] : index searched first (expected < N)
//   found            : at least one request is asserted
//   idx   [SEL_BITS] : index of the winning request (0 when none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N        = 4,
    parameter int SEL_BITS = 2
) (
    input  logic [N-1:0]        req,
    input  logic [SEL_BITS-1:0] ptr,
    output logic                found,
    output logic [SEL_BITS-1:0] idx
);

    // Scan from the farthest rotation back to ptr so the closest hit wins last.
    always_comb begin
        int                  cand;
        logic [SEL_BITS-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = SEL_BITS'(cand);
            found    = req[cand_idx] ? 1'b1     : found;
            idx      = req[cand_idx] ? cand_idx : idx;
        end
    end

endmodule

// File: rtl/shared_mux_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mux_arbiter
// Round-robin arbiter sharing one registered N:1 mux lane between N
// requesters. A requester keeps ownership while it holds req; on release the
// lane goes idle for one cycle and the search restarts after the old owner.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : shared_mux_arbiter_if.slave (req, din in; gnt, sel, dout, dout_vld out)
// Parameters: N (2..8) requesters, W data bits, MAX_HOLD (>= 1) hold limit.
// Optional build macro SHARED_MUX_HOLD_LIMIT_EN: once the owner has been BUSY
// for MAX_HOLD cycles while someone else waits, it is released as if it had
// dropped req. Without the macro a grant lasts until the owner lets go.
// -----------------------------------------------------------------------------
module shared_mux_arbiter
    import shared_mux_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int W        = DEF_W,
    parameter int MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    shared_mux_arbiter_if.slave   bus
);

    localparam int SEL_BITS = sel_width(N);
    localparam int HOLD_W   = sel_width(MAX_HOLD);

    if (N < 2 || N > 8 || MAX_HOLD < 1) begin : g_param_err
        $error("shared_mux_arbiter: N must be 2..8 and MAX_HOLD must be >= 1");
    end

    // One-hot grant vector for owner index idx.
    function automatic logic [N-1:0] onehot(input logic [SEL_BITS-1:0] idx);
        logic [N-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    // Index following idx, wrapping N-1 back to 0.
    function automatic logic [SEL_BITS-1:0] next_index(input logic [SEL_BITS-1:0] idx);
        return (idx == SEL_BITS'(N - 1)) ? SEL_BITS'(0) : idx + SEL_BITS'(1);
    endfunction

    state_t              state_r,    state_s;
    logic [N-1:0]        gnt_r,      gnt_s;
    logic [SEL_BITS-1:0] sel_r,      sel_s;
    logic [W-1:0]        dout_r,     dout_s;
    logic                dout_vld_r, dout_vld_s;
    logic [SEL_BITS-1:0] ptr_r,      ptr_s;

    logic                pick_found_s;
    logic [SEL_BITS-1:0] pick_idx_s;
    logic                owner_req_s;
    logic [W-1:0]        owner_din_s;
    logic                force_rel_s;

    rr_pick #(
        .N        (N),
        .SEL_BITS (SEL_BITS)
    ) u_rr_pick (
        .req   (bus.req),
        .ptr   (ptr_r),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    assign owner_req_s = bus.req[sel_r];

    // Owner data mux; only the current owner's slice ever reaches dout.
    always_comb begin
        owner_din_s = '0;
        for (int i = 0; i < N; i++) begin
            owner_din_s = (sel_r == SEL_BITS'(i)) ? bus.din[i*W +: W] : owner_din_s;
        end
    end

`ifdef SHARED_MUX_HOLD_LIMIT_EN
    logic [HOLD_W-1:0] hold_cnt_r, hold_cnt_s;
    logic              hold_at_max_s;
    logic              others_wait_s;

    assign hold_at_max_s = (hold_cnt_r == HOLD_W'(MAX_HOLD - 1));
    assign others_wait_s = |(bus.req & ~gnt_r);
    assign force_rel_s   = hold_at_max_s && others_wait_s;

    // Hold counter: cleared on each new grant, saturates at MAX_HOLD-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_r <= '0;
        end else begin
            hold_cnt_r <= hold_cnt_s;
        end
    end
`else
    assign force_rel_s = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/BUSY controller.
    always_comb begin
        state_s    = state_r;
        gnt_s      = gnt_r;
        sel_s      = sel_r;
        dout_s     = dout_r;
        dout_vld_s = dout_vld_r;
        ptr_s      = ptr_r;
`ifdef SHARED_MUX_HOLD_LIMIT_EN
        hold_cnt_s = hold_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                dout_vld_s = 1'b0;
                if (pick_found_s) begin
                    state_s = BUSY;
                    gnt_s   = onehot(pick_idx_s);
                    sel_s   = pick_idx_s;
`ifdef SHARED_MUX_HOLD_LIMIT_EN
                    hold_cnt_s = '0;
`endif
                end else begin
                    state_s = IDLE;
                    gnt_s   = '0;
                end
            end
            BUSY: begin
                if (owner_req_s && !force_rel_s) begin
                    dout_s     = owner_din_s;
                    dout_vld_s = 1'b1;
`ifdef SHARED_MUX_HOLD_LIMIT_EN
                    hold_cnt_s = hold_at_max_s ? hold_cnt_r : hold_cnt_r + HOLD_W'(1);
`endif
                end else begin
                    // Release (voluntary or forced): dout keeps its last value.
                    state_s    = IDLE;
                    gnt_s      = '0;
                    dout_vld_s = 1'b0;
                    ptr_s      = next_index(sel_r);
                end
            end
            default: begin
                state_s    = IDLE;
                gnt_s      = '0;
                dout_vld_s = 1'b0;
            end
        endcase
    end

    // Controller state and registered lane outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            sel_r      <= '0;
            dout_r     <= '0;
            dout_vld_r <= 1'b0;
            ptr_r      <= '0;
        end else begin
            state_r    <= state_s;
            gnt_r      <= gnt_s;
            sel_r      <= sel_s;
            dout_r     <= dout_s;
            dout_vld_r <= dout_vld_s;
            ptr_r      <= ptr_s;
        end
    end

    assign bus.gnt      = gnt_r;
    assign bus.sel      = sel_r;
    assign bus.dout     = dout_r;
    assign bus.dout_vld = dout_vld_r;

endmodule
